// File: rtl/ddr_cmd_sched_pkg.sv
// Shared definitions for the DDR command scheduler: command encodings and CBA field layout.
package ddr_cmd_sched_pkg;

    localparam int CMD_WIDTH = 3;

    // {ras_n, cas_n, we_n}
    typedef enum logic [CMD_WIDTH-1:0] {
        DDR_CMD_MRS   = 3'b000,
        DDR_CMD_AR    = 3'b001,
        DDR_CMD_PRE   = 3'b010,
        DDR_CMD_ACT   = 3'b011,
        DDR_CMD_WRITE = 3'b100,
        DDR_CMD_READ  = 3'b101,
        DDR_CMD_NOP   = 3'b111
    } ddr_cmd_e;

    localparam int CBA_A_LSB = 0;

    function automatic int cba_ba_lsb(input int a_width);
        return a_width;
    endfunction

    function automatic int cba_cmd_lsb(input int a_width, input int ba_width);
        return a_width + ba_width;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ddr_win_shr.sv
// Delayed fixed-length pulse generator: a start in cycle k drives win_o high
// for cycles k+DELAY .. k+DELAY+LENGTH-1.
module ddr_win_shr #(
    parameter int DELAY  = 1,
    parameter int LENGTH = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    output logic win_o
);

    localparam int W = DELAY + LENGTH - 1;

    if (DELAY < 1 || LENGTH < 1) begin : g_param_chk
        $error("ddr_win_shr: DELAY and LENGTH must both be >= 1");
    end

    logic [W-1:0] sr_q;
    logic [W-1:0] sr_d;

    // Bit i of the shift register holds a start seen i+1 cycles ago.
    assign sr_d = W'({sr_q, start_i});

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign win_o = |sr_q[W-1:DELAY-1];

endmodule

// File: rtl/ddr_cmd_sched.sv
// DDR command scheduler: spaces accepted CBA commands, registers the command pins and
// generates read-sample / write DQS windows. Auto refresh is enabled by DDR_AUTO_REFRESH_EN.
module ddr_cmd_sched
    import ddr_cmd_sched_pkg::*;
#(
    parameter int A_WIDTH      = 13,
    parameter int BA_WIDTH     = 2,
    parameter int BURST_LEN    = 4,
    parameter int CAS_LAT      = 2,
    parameter int T_MRD        = 2,
    parameter int T_RFC        = 15,
    parameter int T_RCD        = 4,
    parameter int T_RP         = 2,
    parameter int T_RD         = 6,
    parameter int T_WR         = 8,
    parameter int REF_INTERVAL = 1560
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  cmd_valid,
    output logic                                  cmd_ready,
    input  logic [CMD_WIDTH+BA_WIDTH+A_WIDTH-1:0] cmd_cba,
    output logic                                  ddr_ras_n,
    output logic                                  ddr_cas_n,
    output logic                                  ddr_we_n,
    output logic [BA_WIDTH-1:0]                   ddr_ba,
    output logic [A_WIDTH-1:0]                    ddr_a,
    output logic                                  wr_dqs_oe,
    output logic                                  wr_dqs_en,
    output logic                                  wdata_ack,
    output logic                                  rd_sample,
    output logic                                  ref_issued
);

    localparam int BEATS   = BURST_LEN / 2;
    localparam int CBA_W   = CMD_WIDTH + BA_WIDTH + A_WIDTH;
    localparam int CMD_LSB = cba_cmd_lsb(A_WIDTH, BA_WIDTH);
    localparam int BA_LSB  = cba_ba_lsb(A_WIDTH);
    localparam int T_MAX   = max_int(max_int(max_int(T_MRD, T_RFC), max_int(T_RCD, T_RP)),
                                     max_int(max_int(T_RD, T_WR), 1));
    localparam int DW      = $clog2(T_MAX + 1);

    if (T_RD < CAS_LAT + BEATS || T_WR < BEATS + 2) begin : g_timing_chk
        $error("ddr_cmd_sched: need T_RD >= CAS_LAT+BEATS and T_WR >= BEATS+2");
    end
    if (!(BURST_LEN == 2 || BURST_LEN == 4 || BURST_LEN == 8) || CAS_LAT < 1 || CAS_LAT > 7)
    begin : g_burst_chk
        $error("ddr_cmd_sched: BURST_LEN must be 2/4/8 and CAS_LAT 1..7");
    end
    if (REF_INTERVAL < 2 || REF_INTERVAL > 65536) begin : g_ref_chk
        $error("ddr_cmd_sched: REF_INTERVAL must fit the 16-bit refresh counter");
    end

    logic [CMD_WIDTH-1:0] cmd;
    logic                 accept;
    logic                 ref_grant;
    logic [DW-1:0]        cmd_dly;
    logic [DW-1:0]        delay_q, delay_d;
    logic [CBA_W-1:0]     cba_q, cba_d;

    assign cmd       = cmd_cba[CMD_LSB +: CMD_WIDTH];
    assign cmd_ready = (delay_q == '0) & ~ref_grant;
    assign accept    = cmd_valid & cmd_ready;

    always_comb begin
        cmd_dly = '0;
        case (cmd)
            DDR_CMD_MRS:   cmd_dly = DW'(T_MRD);
            DDR_CMD_AR:    cmd_dly = DW'(T_RFC);
            DDR_CMD_ACT:   cmd_dly = DW'(T_RCD);
            DDR_CMD_PRE:   cmd_dly = DW'(T_RP);
            DDR_CMD_READ:  cmd_dly = DW'(T_RD);
            DDR_CMD_WRITE: cmd_dly = DW'(T_WR);
            default:       cmd_dly = '0;
        endcase
    end

    // An internal refresh takes the slot exactly like an accepted AR would.
    always_comb begin
        cba_d   = {DDR_CMD_NOP, {(BA_WIDTH + A_WIDTH){1'b0}}};
        delay_d = (delay_q != '0) ? delay_q - 1'b1 : '0;
        if (ref_grant) begin
            cba_d   = {DDR_CMD_AR, {(BA_WIDTH + A_WIDTH){1'b0}}};
            delay_d = DW'(T_RFC);
        end else if (accept) begin
            cba_d   = cmd_cba;
            delay_d = cmd_dly;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cba_q   <= {DDR_CMD_NOP, {(BA_WIDTH + A_WIDTH){1'b0}}};
            delay_q <= '0;
        end else begin
            cba_q   <= cba_d;
            delay_q <= delay_d;
        end
    end

    assign ddr_ras_n = cba_q[CMD_LSB + 2];
    assign ddr_cas_n = cba_q[CMD_LSB + 1];
    assign ddr_we_n  = cba_q[CMD_LSB];
    assign ddr_ba    = cba_q[BA_LSB +: BA_WIDTH];
    assign ddr_a     = cba_q[CBA_A_LSB +: A_WIDTH];

    logic rd_start, wr_start, wr_data_win;

    assign rd_start = accept & (cmd == DDR_CMD_READ);
    assign wr_start = accept & (cmd == DDR_CMD_WRITE);

    ddr_win_shr #(.DELAY(1 + CAS_LAT), .LENGTH(BEATS)) u_rd_win (
        .clk     (clk),
        .reset   (reset),
        .start_i (rd_start),
        .win_o   (rd_sample)
    );

    // Output enable opens one cycle early to cover the DQS preamble.
    ddr_win_shr #(.DELAY(1), .LENGTH(BEATS + 1)) u_oe_win (
        .clk     (clk),
        .reset   (reset),
        .start_i (wr_start),
        .win_o   (wr_dqs_oe)
    );

    ddr_win_shr #(.DELAY(2), .LENGTH(BEATS)) u_wdata_win (
        .clk     (clk),
        .reset   (reset),
        .start_i (wr_start),
        .win_o   (wr_data_win)
    );

    assign wr_dqs_en = wr_data_win;
    assign wdata_ack = wr_data_win;

`ifdef DDR_AUTO_REFRESH_EN
    logic [15:0] ref_cnt_q, ref_cnt_d;
    logic        ref_pending_q, ref_pending_d;
    logic        ref_issued_q;

    assign ref_grant = (delay_q == '0) & ref_pending_q;

    always_comb begin
        ref_cnt_d     = ref_cnt_q - 16'd1;
        ref_pending_d = ref_pending_q & ~ref_grant;
        if (ref_cnt_q == 16'd0) begin
            ref_cnt_d     = 16'(REF_INTERVAL - 1);
            ref_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ref_cnt_q     <= 16'(REF_INTERVAL - 1);
            ref_pending_q <= 1'b0;
            ref_issued_q  <= 1'b0;
        end else begin
            ref_cnt_q     <= ref_cnt_d;
            ref_pending_q <= ref_pending_d;
            ref_issued_q  <= ref_grant;
        end
    end

    assign ref_issued = ref_issued_q;
`else
    assign ref_grant  = 1'b0;
    assign ref_issued = 1'b0;
`endif

endmodule
